// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and default word width for the TX serializer.
package serializer_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/serializer_piso.sv
// serializer_piso: parallel-in serial-out shifter with gapless back-to-back reload on the final bit.
module serializer_piso
  import serializer_pkg::*;
#(
  parameter int   DATA_WIDTH = DATA_WIDTH_DEF,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LOAD,
  input  logic [DATA_WIDTH-1:0] BUFF,
  output logic                  sdo,
  output logic                  ready,
  output logic                  TX_active,
  output logic                  shift
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic last, accept;
  always_comb begin
    last = state == SHIFT && cnt == LAST;
    accept = LOAD && (state == IDLE || last);
    state_nx = state;
    sreg_nx = sreg;
    cnt_nx = cnt;
    if (accept) begin
      state_nx = SHIFT;
      sreg_nx = BUFF;
      cnt_nx = '0;
    end else if (state == SHIFT) begin
      state_nx = last ? IDLE : SHIFT;
      sreg_nx = MSB_FIRST ? {sreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, sreg[DATA_WIDTH-1:1]};
      cnt_nx = last ? '0 : cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      cnt <= cnt_nx;
    end
  assign ready = state == IDLE;
  assign TX_active = state == SHIFT;
  assign shift = TX_active && cnt != LAST;
  assign sdo = TX_active ? (MSB_FIRST ? sreg[DATA_WIDTH-1] : sreg[0]) : IDLE_LEVEL;
endmodule

// File: tb/tb_serializer_piso.sv
// tb_serializer_piso: scoreboard bench for LSB-first and MSB-first serializer instances.
module tb_serializer_piso;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load0 = 1'b0, load1 = 1'b0;
  logic [7:0] buff0 = '0, buff1 = '0;
  logic sdo0, ready0, act0, shift0;
  logic sdo1, ready1, act1, shift1;
  int checks = 0, failures = 0;
  int pos0 = 0, pos1 = 0;
  logic q0[$], q1[$];

  serializer_piso #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .LOAD(load0), .BUFF(buff0),
    .sdo(sdo0), .ready(ready0), .TX_active(act0), .shift(shift0));
  serializer_piso #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst(rst), .LOAD(load1), .BUFF(buff1),
    .sdo(sdo1), .ready(ready1), .TX_active(act1), .shift(shift1));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // seq is written in transmission order: seq[7] is the first bit on the line
  task automatic push(input int d, input logic [7:0] seq);
    for (int i = 7; i >= 0; i--)
      if (d == 0) q0.push_back(seq[i]);
      else q1.push_back(seq[i]);
  endtask

  task automatic monitor_step(input int d, input logic s, input logic r, input logic a,
                              input logic sh, input int pos_in, output int pos_out);
    logic exp;
    check($sformatf("ready_vs_active%0d", d), int'(r), int'(!a));
    pos_out = 0;
    if (a) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit%0d actual=%0d required=no_frame", d, s);
      end else begin
        exp = d == 0 ? q0.pop_front() : q1.pop_front();
        check($sformatf("sdo_bit%0d", d), int'(s), int'(exp));
      end
      check($sformatf("shift%0d_pos%0d", d, pos_in), int'(sh), int'(pos_in != 7));
      pos_out = pos_in == 7 ? 0 : pos_in + 1;
    end else begin
      check($sformatf("sdo_idle%0d", d), int'(s), 0);
      check($sformatf("shift_idle%0d", d), int'(sh), 0);
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0, sdo0, ready0, act0, shift0, pos0, pos0);
    monitor_step(1, sdo1, ready1, act1, shift1, pos1, pos1);
  end

  task automatic idle_check(input string name);
    check({name, "_ready"}, int'(ready0), 1);
    check({name, "_active"}, int'(act0), 0);
    check({name, "_drained"}, q0.size(), 0);
  endtask

  initial begin
    #2;
    check("rst_sdo", int'(sdo0), 0);
    check("rst_ready", int'(ready0), 1);
    check("rst_active", int'(act0), 0);
    check("rst_shift", int'(shift0), 0);
    check("rst_ready_msb", int'(ready1), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 idle_check("post_release");
    // single LSB-first frame of 0xA5
    buff0 = 8'hA5; load0 = 1'b1; push(0, 8'b10100101);
    @(posedge clk); #1 load0 = 1'b0;
    repeat (9) @(posedge clk);
    #1 idle_check("single_a5");
    // MSB-first: 0xA5 then 0x0F
    buff1 = 8'hA5; load1 = 1'b1; push(1, 8'b10100101);
    @(posedge clk); #1 load1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 buff1 = 8'h0F; load1 = 1'b1; push(1, 8'b00001111);
    @(posedge clk); #1 load1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("msb_drained", q1.size(), 0);
    check("msb_ready", int'(ready1), 1);
    // back-to-back 0x3C then 0xC3 with LOAD held
    buff0 = 8'h3C; load0 = 1'b1; push(0, 8'b00111100);
    @(posedge clk); #1 buff0 = 8'hC3; push(0, 8'b11000011);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("b2b_active_%0d", i), int'(act0), 1);
      check($sformatf("b2b_ready_%0d", i), int'(ready0), 0);
      if (i == 8) load0 = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 idle_check("b2b");
    // mid-frame LOAD and BUFF change are ignored
    buff0 = 8'hFF; load0 = 1'b1; push(0, 8'b11111111);
    @(posedge clk); #1 load0 = 1'b0; buff0 = 8'h00;
    repeat (3) @(posedge clk);
    #1 load0 = 1'b1;
    @(posedge clk); #1 load0 = 1'b0;
    repeat (8) @(posedge clk);
    #1 idle_check("ignored_load");
    // reset after three bits of 0xA5 aborts the frame
    buff0 = 8'hA5; load0 = 1'b1; push(0, 8'b10100101);
    @(posedge clk); #1 load0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    q0.delete();
    #1;
    check("abort_sdo", int'(sdo0), 0);
    check("abort_ready", int'(ready0), 1);
    check("abort_active", int'(act0), 0);
    check("abort_shift", int'(shift0), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 idle_check("abort_release");
    buff0 = 8'h0F; load0 = 1'b1; push(0, 8'b11110000);
    @(posedge clk); #1 load0 = 1'b0;
    repeat (9) @(posedge clk);
    #1 idle_check("after_abort");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serializer_piso.md
# serializer_piso

Parallel-in, serial-out serializer for the transceiver TX path. It captures a DATA_WIDTH-bit word from the parallel buffer on a LOAD request and shifts it out one bit per clock on a single serial line. It reports idle/busy status so the upstream buffer logic knows when to present the next word. It sits between the TX word buffer and the line driver.

## Interface
- DATA_WIDTH, 8: parallel word width; legal range is 2 or more.
- MSB_FIRST, 0: 0 shifts bit 0 out first; 1 shifts bit DATA_WIDTH-1 out first.
- IDLE_LEVEL, 1'b0: value driven on `sdo` when no frame is in progress.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- LOAD  input  1  load request; level-sampled on the rising edge.
- BUFF  input  DATA_WIDTH  parallel word; captured on an accepted load.
- sdo  output  1  serial data out, registered.
- ready  output  1  high in IDLE; a LOAD seen while ready is high is accepted.
- TX_active  output  1  high for exactly DATA_WIDTH cycles per frame.
- shift  output  1  high on cycles where the shift register advances at the next edge.

## Operation
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - ready=1, TX_active=0, shift=0, sdo=IDLE_LEVEL.
  - LOAD=1 at an edge: capture BUFF into the shift register, clear the bit counter, and move to SHIFT.
- SHIFT:
  - sdo presents the current first-out bit of the shift register.
  - Each edge shifts the register by one bit toward the output and increments the counter.
  - At the edge where counter = DATA_WIDTH-1, the FSM returns to IDLE.
  - If LOAD=1 at that same edge, the FSM reloads from BUFF instead and stays in SHIFT. This gives back-to-back frames with no gap, and ready is not asserted between them.
- LOAD is ignored in SHIFT except at the final-bit edge.
- BUFF changes after capture have no effect on the frame in progress.
- The counter is $clog2(DATA_WIDTH) bits wide and never exceeds DATA_WIDTH-1.
- shift = TX_active and (counter ≠ DATA_WIDTH-1).
- Reset, when asserted, forces immediately:
  - state=IDLE, shift register=0, counter=0;
  - sdo=IDLE_LEVEL, ready=1, TX_active=0, shift=0.
- Reset asserted mid-frame aborts the frame; no remaining bits are emitted.

## Timing
- Load accepted at edge k: from edge k, TX_active=1, ready=0, and sdo holds first-out bit b0.
- sdo carries bit b(i) in the cycle following edge k+i, for i = 0 to DATA_WIDTH-1.
- At edge k+DATA_WIDTH, without a reload: ready=1, TX_active=0, sdo=IDLE_LEVEL.
- Load-to-first-bit latency is 0 cycles after the accepting edge; one frame occupies DATA_WIDTH cycles.
- With LOAD held high continuously, a new frame starts every DATA_WIDTH cycles.
- Reset deassertion takes effect at the next edge; a LOAD sampled at that edge is accepted.

## Structure
- Shared package serializer_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - the default DATA_WIDTH constant, for use by the transceiver top.
- Single module with no sub-modules. The counter and shift register are inline.

## Test plan
- Reset: with rst=0 during activity → sdo=0, ready=1, TX_active=0, shift=0 immediately; still idle after release with LOAD=0.
- Single frame, default parameters, BUFF=0xA5, LOAD pulsed for one cycle → sdo = 1,0,1,0,0,1,0,1 on consecutive cycles; TX_active high for exactly 8 cycles; shift high for the first 7 of them; ready returns to 1.
- MSB_FIRST=1, BUFF=0xA5 → sdo = 1,0,1,0,0,1,0,1, which is the same pattern as LSB-first because 0xA5 is a bit palindrome. Repeat with BUFF=0x0F → sdo = 0,0,0,0,1,1,1,1.
- LOAD held high with BUFF alternating 0x3C and 0xC3 at each accept → 16 contiguous bits with no idle cycle; ready stays 0 throughout.
- LOAD pulsed and BUFF changed mid-frame (frame started with 0xFF, BUFF changed to 0x00) → all 8 bits remain 1; the LOAD is ignored.
- rst asserted after 3 bits of 0xA5 → sdo=0 and ready=1 at once; no further bits; a fresh load after release transmits normally.
